vend_dispenser: RTL and testbench
=================================

Name: vend_dispenser

Overview:
- Downstream stage of the coin-accumulating vend controller.
- Consumes that controller's `give_soda`/`give_diet` vend request and its `change_count` (nickels owed).
- Drives the product solenoids and the nickel-eject solenoid through timed pulses, and confirms each actuation with a physical sensor.
- Reports busy, done and fault status to the front panel.

Parameters:
- PULSE_CYCLES, 16: solenoid on-time per actuation, in clk cycles (>=1).
- TIMEOUT_CYCLES, 1024: maximum wait for a sensor confirmation after the pulse ends.
- GAP_CYCLES, 4: idle cycles between consecutive nickel ejects (>=1).
- CNT_W, 3: width of `change_count` and of the internal nickel counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- give_soda  in  1  soda vend request (level from upstream).
- give_diet  in  1  diet vend request (level from upstream).
- change_count  in  CNT_W  number of nickels to return; sampled at request acceptance.
- drop_sense  in  1  product-drop sensor, high for >=1 cycle per item.
- coin_sense  in  1  coin-chute sensor, high for >=1 cycle per nickel.
- clear_fault  in  1  operator fault acknowledge.
- soda_motor  out  1  soda solenoid drive.
- diet_motor  out  1  diet solenoid drive.
- coin_eject  out  1  nickel solenoid drive.
- busy  out  1  transaction in progress (also high in FAULT).
- done  out  1  one-cycle pulse when a transaction completes.
- fault  out  1  sticky fault flag.
- fault_code  out  2  00 none, 01 product timeout, 10 coin timeout.

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; all counters and edge-detect registers cleared. Reset mid-operation drops every solenoid in the same instant, and the transaction is abandoned.
- Request detection: registered previous values of `give_soda`, `give_diet` and (`change_count != 0`). A start occurs in IDLE on a rising edge of any of these.
- Latched at start:
  - product = soda if `give_soda`, else diet if `give_diet`, else none. If both are high, soda wins.
  - nickels_left = `change_count`.
- Edges seen outside IDLE are ignored. No queuing: upstream issues one transaction at a time.
- A start with product none and `change_count` 0 is impossible by construction.
- States and transitions:
  - IDLE:
    - on start with a product -> PROD_PULSE;
    - on start with no product and nickels_left > 0 -> COIN_PULSE.
  - PROD_PULSE: selected motor high for exactly PULSE_CYCLES cycles -> PROD_WAIT.
    - A `drop_sense` seen during the pulse is latched and counts as confirmation.
  - PROD_WAIT: motor low.
    - On confirmation: -> COIN_PULSE if nickels_left > 0, else -> DONE.
    - After TIMEOUT_CYCLES without confirmation: -> FAULT, code 01.
  - COIN_PULSE: `coin_eject` high for PULSE_CYCLES cycles -> COIN_WAIT. `coin_sense` during the pulse is latched.
  - COIN_WAIT: on confirmation, nickels_left decrements.
    - If the new value > 0 -> COIN_GAP; else -> DONE.
    - Timeout -> FAULT, code 10.
  - COIN_GAP: GAP_CYCLES idle cycles -> COIN_PULSE.
  - DONE: `done` = 1 for one cycle, `busy` = 0 -> IDLE.
  - FAULT: all solenoids 0; `busy` = 1; `fault` = 1; code held. On `clear_fault` -> IDLE, fault and code cleared the same edge.
- `busy` = 1 in every state except IDLE and DONE.
- Latency: the motor asserts on the cycle after the start edge is registered, i.e. 2 clk edges after the request input rises.
- Confirmation sensing:
  - one confirmation per actuation;
  - extra sensor pulses in other states are ignored;
  - a held-high sensor counts once (rising-edge detected).
- Counters:
  - pulse/gap/timeout share one down-counter of width clog2(max(PULSE_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES)) + 1;
  - nickels_left never wraps: decrement only when > 0.
- Only one solenoid is high in any cycle.

Decomposition:
- Shared package `vend_pkg`: state enum, fault code constants (FAULT_NONE, FAULT_PROD, FAULT_COIN), product-select encoding.
- One sub-module `pulse_timer`: load value, start, expired flag; reused for pulse, gap and timeout timing.

Test Plan:
1. `give_soda` rises, `change_count` 0, `drop_sense` 5 cycles after the pulse ends -> `soda_motor` high exactly 16 cycles, `done` pulse, no coin_eject, `busy` back to 0.
2. `give_diet` with `change_count` = 2, sensors answer each actuation -> `diet_motor` 16 cycles, then two `coin_eject` pulses separated by >= 4 idle cycles plus the wait, then `done`.
3. `give_soda` and `give_diet` rise together with `change_count` = 1 -> only `soda_motor` fires, then one nickel.
4. Product request, `drop_sense` never asserted -> FAULT after 16+1024 cycles, `fault_code` 01, all motors 0, `busy` 1; `clear_fault` -> IDLE, `fault` 0.
5. Change-only request (`change_count` 0 -> 3, no product), `coin_sense` missing on the 2nd nickel -> FAULT, code 10, nickels_left = 2 at fault.
6. Assert `reset` mid COIN_PULSE -> `coin_eject` drops asynchronously, and a new request after reset starts cleanly from IDLE.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vend dispenser: FSM states, fault codes, product select, sizing helper.
// Pure declarations; no timing or flow control of its own.
`timescale 1ns/1ps
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROD_PULSE,
    ST_PROD_WAIT,
    ST_COIN_PULSE,
    ST_COIN_WAIT,
    ST_COIN_GAP,
    ST_DONE,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    PROD_NONE,
    PROD_SODA,
    PROD_DIET
  } prod_t;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_PROD = 2'b01;
  localparam logic [1:0] FAULT_COIN = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; expired is high during the last of load_val cycles after a load.
// Load takes effect on the next edge; no flow control.
`timescale 1ns/1ps
module pulse_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Holding at zero keeps an unloaded timer from ever expiring again.
  assign expired = (cnt == W'(1));

endmodule

// File: rtl/vend_dispenser.sv
// Vend dispenser: timed product/nickel solenoid pulses, each confirmed by a sensor; busy/done/fault status.
// Latency: solenoid rises 2 clk edges after the request; no backpressure, one transaction at a time.
`timescale 1ns/1ps
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 4,
  parameter int CNT_W          = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             give_soda,
  input  logic             give_diet,
  input  logic [CNT_W-1:0] change_count,
  input  logic             drop_sense,
  input  logic             coin_sense,
  input  logic             clear_fault,
  output logic             soda_motor,
  output logic             diet_motor,
  output logic             coin_eject,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int TW = $clog2(max3(PULSE_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [TW-1:0] LD_PULSE   = TW'(PULSE_CYCLES);
  localparam logic [TW-1:0] LD_TIMEOUT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LD_GAP     = TW'(GAP_CYCLES);

  state_t           state, state_nx;
  prod_t            product;
  logic [CNT_W-1:0] nickels_left;
  logic [CNT_W-1:0] cc_q;
  logic [1:0]       fault_code_q;
  logic             soda_q, diet_q, nz_q;
  logic             soda_p, diet_p, nz_p;
  logic             drop_p, coin_p;
  logic             confirmed;
  logic             start, sense_rise, confirm_now;
  logic             tmr_load, tmr_exp;
  logic [TW-1:0]    tmr_val;

  // Requests are sampled once, then edge-detected against a second stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      soda_q <= 1'b0;
      diet_q <= 1'b0;
      nz_q   <= 1'b0;
      cc_q   <= '0;
      soda_p <= 1'b0;
      diet_p <= 1'b0;
      nz_p   <= 1'b0;
      drop_p <= 1'b0;
      coin_p <= 1'b0;
    end else begin
      soda_q <= give_soda;
      diet_q <= give_diet;
      nz_q   <= (change_count != '0);
      cc_q   <= change_count;
      soda_p <= soda_q;
      diet_p <= diet_q;
      nz_p   <= nz_q;
      drop_p <= drop_sense;
      coin_p <= coin_sense;
    end
  end

  assign start = (state == ST_IDLE) &&
                 ((soda_q & ~soda_p) | (diet_q & ~diet_p) | (nz_q & ~nz_p));

  always_comb begin
    sense_rise = 1'b0;
    case (state)
      ST_PROD_PULSE, ST_PROD_WAIT: sense_rise = drop_sense & ~drop_p;
      ST_COIN_PULSE, ST_COIN_WAIT: sense_rise = coin_sense & ~coin_p;
      default: ;
    endcase
  end

  assign confirm_now = confirmed | sense_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (soda_q || diet_q)    state_nx = ST_PROD_PULSE;
          else if (cc_q != '0)     state_nx = ST_COIN_PULSE;
        end
      end
      ST_PROD_PULSE: if (tmr_exp) state_nx = ST_PROD_WAIT;
      ST_PROD_WAIT: begin
        if (confirm_now)   state_nx = (nickels_left != '0) ? ST_COIN_PULSE : ST_DONE;
        else if (tmr_exp)  state_nx = ST_FAULT;
      end
      ST_COIN_PULSE: if (tmr_exp) state_nx = ST_COIN_WAIT;
      ST_COIN_WAIT: begin
        if (confirm_now)   state_nx = (nickels_left > CNT_W'(1)) ? ST_COIN_GAP : ST_DONE;
        else if (tmr_exp)  state_nx = ST_FAULT;
      end
      ST_COIN_GAP:   if (tmr_exp) state_nx = ST_COIN_PULSE;
      ST_DONE:       state_nx = ST_IDLE;
      ST_FAULT:      if (clear_fault) state_nx = ST_IDLE;
      default:       state_nx = ST_IDLE;
    endcase
  end

  // Every state change reloads the shared timer with the new state's duration.
  always_comb begin
    tmr_load = (state_nx != state);
    tmr_val  = '0;
    case (state_nx)
      ST_PROD_PULSE, ST_COIN_PULSE: tmr_val = LD_PULSE;
      ST_PROD_WAIT, ST_COIN_WAIT:   tmr_val = LD_TIMEOUT;
      ST_COIN_GAP:                  tmr_val = LD_GAP;
      default:                      tmr_val = '0;
    endcase
  end

  pulse_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product      <= PROD_NONE;
      nickels_left <= '0;
      confirmed    <= 1'b0;
      fault_code_q <= FAULT_NONE;
    end else begin
      if (start) begin
        product      <= soda_q ? PROD_SODA : (diet_q ? PROD_DIET : PROD_NONE);
        nickels_left <= cc_q;
      end else if (state == ST_COIN_WAIT && confirm_now && nickels_left != '0) begin
        nickels_left <= nickels_left - CNT_W'(1);
      end

      // One confirmation per actuation: cleared as each pulse begins.
      if (tmr_load && (state_nx == ST_PROD_PULSE || state_nx == ST_COIN_PULSE)) begin
        confirmed <= 1'b0;
      end else if (sense_rise) begin
        confirmed <= 1'b1;
      end

      if (state_nx == ST_FAULT && state != ST_FAULT) begin
        fault_code_q <= (state == ST_PROD_WAIT) ? FAULT_PROD : FAULT_COIN;
      end else if (state == ST_FAULT && clear_fault) begin
        fault_code_q <= FAULT_NONE;
      end
    end
  end

  always_comb begin
    soda_motor = 1'b0;
    diet_motor = 1'b0;
    coin_eject = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    fault      = 1'b0;
    fault_code = fault_code_q;
    case (state)
      ST_IDLE:       busy = 1'b0;
      ST_PROD_PULSE: begin
        soda_motor = (product == PROD_SODA);
        diet_motor = (product == PROD_DIET);
      end
      ST_COIN_PULSE: coin_eject = 1'b1;
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      ST_FAULT:      fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// Bench for vend_dispenser: sensor responder, pulse/event monitor, scoreboard of expected events.
`timescale 1ns/1ps
module tb_vend_dispenser;

  localparam int PULSE = 16;
  localparam int TMO   = 1024;
  localparam int GAP   = 4;

  localparam int EV_SODA  = 0;
  localparam int EV_DIET  = 1;
  localparam int EV_COIN  = 2;
  localparam int EV_DONE  = 3;
  localparam int EV_FAULT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       give_soda, give_diet;
  logic [2:0] change_count;
  logic       drop_sense, coin_sense, clear_fault;
  logic       soda_motor, diet_motor, coin_eject;
  logic       busy, done, fault;
  logic [1:0] fault_code;

  bit         drop_ok;
  bit [7:0]   coin_ok;

  typedef struct {
    int kind;
    int val;
  } ev_t;
  ev_t sb_q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vend_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .give_soda    (give_soda),
    .give_diet    (give_diet),
    .change_count (change_count),
    .drop_sense   (drop_sense),
    .coin_sense   (coin_sense),
    .clear_fault  (clear_fault),
    .soda_motor   (soda_motor),
    .diet_motor   (diet_motor),
    .coin_eject   (coin_eject),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_match(input int kind, input int val);
    ev_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_unexpected_event", kind, -1);
    end else begin
      e = sb_q.pop_front();
      check_eq("sb_kind", kind, e.kind);
      check_eq("sb_val", val, e.val);
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, int'(busy), 0);
  endtask

  // Monitor: turns solenoid pulses, done and fault entry into events for the scoreboard.
  initial begin
    int  soda_len = 0, diet_len = 0, coin_len = 0, gap_cnt = 0;
    bit  gap_vld = 1'b0, fault_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        soda_len = 0; diet_len = 0; coin_len = 0;
        gap_vld = 1'b0; fault_prev = 1'b0;
        continue;
      end
      if (soda_motor | diet_motor | coin_eject)
        check_eq("one_solenoid", int'(soda_motor) + int'(diet_motor) + int'(coin_eject), 1);
      if (soda_motor) soda_len++;
      else if (soda_len > 0) begin sb_match(EV_SODA, soda_len); soda_len = 0; end
      if (diet_motor) diet_len++;
      else if (diet_len > 0) begin sb_match(EV_DIET, diet_len); diet_len = 0; end
      if (coin_eject) begin
        if (coin_len == 0 && gap_vld) check_eq("coin_gap_over_min", int'(gap_cnt > GAP), 1);
        coin_len++;
      end else if (coin_len > 0) begin
        sb_match(EV_COIN, coin_len);
        coin_len = 0;
        gap_vld  = 1'b1;
        gap_cnt  = 1;
      end else if (gap_vld) begin
        gap_cnt++;
      end
      if (done) begin
        sb_match(EV_DONE, 0);
        gap_vld = 1'b0;
      end
      if (fault && !fault_prev) begin
        sb_match(EV_FAULT, int'(fault_code));
        gap_vld = 1'b0;
      end
      fault_prev = fault;
    end
  end

  // Sensor responder: answers each actuation after it ends, as enabled by drop_ok / coin_ok.
  initial begin
    bit prod_prev = 1'b0, coin_prev = 1'b0;
    int idx = 0;
    drop_sense = 1'b0;
    coin_sense = 1'b0;
    forever begin
      @(negedge clk);
      if (!busy) idx = 0;
      if (prod_prev && !(soda_motor | diet_motor)) begin
        if (drop_ok) begin
          repeat (4) @(negedge clk);
          drop_sense = 1'b1;
          @(negedge clk);
          drop_sense = 1'b0;
        end
      end else if (coin_prev && !coin_eject) begin
        if (coin_ok[idx[2:0]]) begin
          repeat (2) @(negedge clk);
          coin_sense = 1'b1;
          @(negedge clk);
          coin_sense = 1'b0;
        end
        idx++;
      end
      prod_prev = soda_motor | diet_motor;
      coin_prev = coin_eject;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    int n;
    reset        = 1'b1;
    give_soda    = 1'b0;
    give_diet    = 1'b0;
    change_count = 3'd0;
    clear_fault  = 1'b0;
    drop_ok      = 1'b1;
    coin_ok      = 8'hFF;
    repeat (3) @(negedge clk);
    check_eq("rst_soda",  int'(soda_motor), 0);
    check_eq("rst_diet",  int'(diet_motor), 0);
    check_eq("rst_coin",  int'(coin_eject), 0);
    check_eq("rst_busy",  int'(busy), 0);
    check_eq("rst_done",  int'(done), 0);
    check_eq("rst_fault", int'(fault), 0);
    check_eq("rst_code",  int'(fault_code), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: soda, no change
    sb_push(EV_SODA, PULSE); sb_push(EV_DONE, 0);
    give_soda = 1'b1;
    @(negedge clk); check_eq("t1_lat_edge1", int'(soda_motor), 0);
    @(negedge clk); check_eq("t1_lat_edge2", int'(soda_motor), 1);
    check_eq("t1_busy", int'(busy), 1);
    wait_idle("t1_idle", 300);
    give_soda = 1'b0;
    repeat (3) @(negedge clk);

    // 2: diet with two nickels
    sb_push(EV_DIET, PULSE); sb_push(EV_COIN, PULSE); sb_push(EV_COIN, PULSE); sb_push(EV_DONE, 0);
    give_diet = 1'b1; change_count = 3'd2;
    repeat (2) @(negedge clk);
    check_eq("t2_diet_on", int'(diet_motor), 1);
    wait_idle("t2_idle", 500);
    give_diet = 1'b0; change_count = 3'd0;
    repeat (3) @(negedge clk);

    // 3: both products together, soda wins, one nickel
    sb_push(EV_SODA, PULSE); sb_push(EV_COIN, PULSE); sb_push(EV_DONE, 0);
    give_soda = 1'b1; give_diet = 1'b1; change_count = 3'd1;
    repeat (2) @(negedge clk);
    wait_idle("t3_idle", 500);
    give_soda = 1'b0; give_diet = 1'b0; change_count = 3'd0;
    repeat (3) @(negedge clk);

    // 4: product timeout
    drop_ok = 1'b0;
    sb_push(EV_SODA, PULSE); sb_push(EV_FAULT, 1);
    give_soda = 1'b1;
    n = 0;
    while (!soda_motor && n < 10) begin @(negedge clk); n++; end
    check_eq("t4_motor_on", int'(soda_motor), 1);
    n = 0;
    while (!fault && n < 2000) begin @(negedge clk); n++; end
    check_eq("t4_fault_cycles", n, PULSE + TMO);
    check_eq("t4_code", int'(fault_code), 1);
    check_eq("t4_motors_off", int'(soda_motor | diet_motor | coin_eject), 0);
    check_eq("t4_busy", int'(busy), 1);
    give_soda = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t4_sticky", int'(fault), 1);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    check_eq("t4_clr_fault", int'(fault), 0);
    check_eq("t4_clr_code", int'(fault_code), 0);
    check_eq("t4_clr_busy", int'(busy), 0);
    drop_ok = 1'b1;
    repeat (3) @(negedge clk);

    // 5: change only, second nickel never confirmed
    coin_ok = 8'h01;
    sb_push(EV_COIN, PULSE); sb_push(EV_COIN, PULSE); sb_push(EV_FAULT, 2);
    change_count = 3'd3;
    n = 0;
    while (!fault && n < 3000) begin @(negedge clk); n++; end
    check_eq("t5_fault", int'(fault), 1);
    check_eq("t5_code", int'(fault_code), 2);
    check_eq("t5_nickels_left", int'(dut.nickels_left), 2);
    clear_fault = 1'b1; change_count = 3'd0;
    @(negedge clk);
    clear_fault = 1'b0;
    check_eq("t5_clr_fault", int'(fault), 0);
    coin_ok = 8'hFF;
    repeat (3) @(negedge clk);

    // 6: reset mid coin pulse, then a clean new transaction
    change_count = 3'd2;
    n = 0;
    while (!coin_eject && n < 10) begin @(negedge clk); n++; end
    check_eq("t6_coin_on", int'(coin_eject), 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t6_async_coin_drop", int'(coin_eject), 0);
    check_eq("t6_async_busy", int'(busy), 0);
    change_count = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("t6_idle_after_rst", int'(busy), 0);
    sb_push(EV_SODA, PULSE); sb_push(EV_COIN, PULSE); sb_push(EV_DONE, 0);
    give_soda = 1'b1; change_count = 3'd1;
    @(negedge clk); check_eq("t6_lat_edge1", int'(soda_motor), 0);
    @(negedge clk); check_eq("t6_lat_edge2", int'(soda_motor), 1);
    wait_idle("t6_idle", 500);
    give_soda = 1'b0; change_count = 3'd0;
    repeat (5) @(negedge clk);

    check_eq("sb_drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
